my_rr_arbiter8: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters. It uses an instance of `my_or8way` to detect any pending request, then registers a one-hot grant. The grant is held until the granted requester releases. It sits in front of any shared datapath unit (memory port, ALU slot) where up to eight sources compete.

---
 rtl/my_arb_pkg.sv | 27 ++
 rtl/my_or8way.sv | 9 +
 rtl/my_rr_pick8.sv | 26 ++
 rtl/my_rr_arbiter8.sv | 139 +++++++++++++
 tb/tb_my_rr_arbiter8.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/my_arb_pkg.sv
// Shared constants, state encoding and debug view for the round-robin arbiter family.
// The default hold limit only matters when MY_RR_ARB_TIMEOUT_EN is defined.
package my_arb_pkg;

    localparam int NREQ             = 8;
    localparam int ID_W             = 3;
    localparam int CNT_W            = 8;
    localparam int HOLD_MAX_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        arb_state_t        state;
        logic [ID_W-1:0]   ptr;
        logic [CNT_W-1:0]  hold_cnt;
    } arb_dbg_t;

    function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] one;
        one = 1;
        return one << id;
    endfunction

endpackage

// File: rtl/my_or8way.sv
// Eight-input OR reduction, used to flag any pending request.
module my_or8way (
    input  logic [7:0] a,
    output logic       y
);

    assign y = |a;

endmodule

// File: rtl/my_rr_pick8.sv
// Rotated priority search: first set req bit in the order ptr, ptr+1, ... ptr+7 (mod 8).
module my_rr_pick8
    import my_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner_id,
    output logic            winner_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner_id    = '0;
        winner_valid = 1'b0;
        idx          = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!winner_valid && req[idx]) begin
                winner_id    = idx;
                winner_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/my_rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant held until release.
// Optional forced rotation after HOLD_MAX cycles when MY_RR_ARB_TIMEOUT_EN is defined.
module my_rr_arbiter8
    import my_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            any_req,
    output arb_dbg_t        dbg
);

    // Handshake: a requester raises req[i] and keeps it high for as long as it
    // needs the resource; grant[i] rises one edge later and stays until the edge
    // on which req[i] is seen low (or a timeout preempts), when it moves on.

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t        state, state_n;
    logic [NREQ-1:0]   grant_q, grant_n;
    logic [ID_W-1:0]   gid_q, gid_n;
    logic [ID_W-1:0]   ptr_q, ptr_n;
    logic [CNT_W-1:0]  hold_cnt;
    logic              load;
    logic              timeout;
    logic [NREQ-1:0]   pick_req;
    logic [ID_W-1:0]   pick_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_valid;

    my_or8way u_or (
        .a (req),
        .y (any_req)
    );

    // One search serves both paths: from ptr when idle, from the holder's
    // successor (holder masked out) when handing over or preempting.
    assign pick_req = req & ~grant_q;
    assign pick_ptr = (state == GRANT) ? gid_q + 3'd1 : ptr_q;

    my_rr_pick8 u_pick (
        .req          (pick_req),
        .ptr          (pick_ptr),
        .winner_id    (win_id),
        .winner_valid (win_valid)
    );

`ifdef MY_RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(HOLD_MAX);
    logic [CNT_W-1:0] hold_cnt_n;

    always_comb begin
        hold_cnt_n = hold_cnt;
        if (load || state_n == IDLE) begin
            hold_cnt_n = '0;
        end else if (hold_cnt < HOLD_SAT) begin
            hold_cnt_n = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_n;
        end
    end
`else
    localparam bit TIMEOUT_EN = 1'b0;
    assign hold_cnt = '0;
`endif

    assign timeout = TIMEOUT_EN && (hold_cnt == HOLD_LAST) && win_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            gid_q   <= gid_n;
            ptr_q   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        gid_n   = gid_q;
        ptr_n   = ptr_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    grant_n = id_to_onehot(win_id);
                    gid_n   = win_id;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!req[gid_q] || timeout) begin
                    ptr_n = gid_q + 3'd1;
                    if (win_valid) begin
                        load    = 1'b1;
                        grant_n = id_to_onehot(win_id);
                        gid_n   = win_id;
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        grant        = grant_q;
        grant_id     = gid_q;
        busy         = |grant_q;
        dbg.state    = state;
        dbg.ptr      = ptr_q;
        dbg.hold_cnt = hold_cnt;
    end

endmodule

// File: tb/tb_my_rr_arbiter8.sv
// Directed and randomized checks of my_rr_arbiter8 against a queue-free behavioural model.
// Follows MY_RR_ARB_TIMEOUT_EN so either build of the arbiter can be exercised.
module tb_my_rr_arbiter8;
    import my_arb_pkg::*;

    localparam int HM = 4;
`ifdef MY_RR_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       any_req;
    arb_dbg_t   dbg;

    int checks = 0;
    int failures = 0;

    int m_holder = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    my_rr_arbiter8 #(.HOLD_MAX(HM)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .any_req  (any_req),
        .dbg      (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_winner(input logic [7:0] r, input int p, input int excl);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (p + k) % 8;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        if (m_holder < 0) begin
            if (r != 8'h00) begin
                m_holder = find_winner(r, m_ptr, -1);
                m_cnt = 0;
            end
        end else begin
            bit released, others, preempt;
            int w;
            released = !r[m_holder];
            others = find_winner(r, 0, m_holder) >= 0;
            preempt = TMO && (m_cnt == HM - 1) && others;
            if (released || preempt) begin
                m_ptr = (m_holder + 1) % 8;
                w = find_winner(r, m_ptr, m_holder);
                m_holder = w;
                m_cnt = 0;
            end else if (TMO && m_cnt < HM) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_grant;
        exp_grant = (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
        check("grant", grant, exp_grant);
        check("busy", busy, m_holder >= 0);
        if (m_holder >= 0) check("grant_id", grant_id, m_holder);
        check("ptr", dbg.ptr, m_ptr);
        check("state", dbg.state, (m_holder >= 0) ? GRANT : IDLE);
        check("hold_cnt", dbg.hold_cnt, m_cnt);
        check("onehot", $countones(grant) <= 1, 1);
    endtask

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        #1;
        check("any_req", any_req, |r);
        @(posedge clk);
        model_step(r);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 8'h00;
        #1;
        check("rst_grant", grant, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #3;
        check("por_grant", grant, 8'h00);
        check("por_busy", busy, 0);
        check("por_any_req", any_req, 0);
        check("por_ptr", dbg.ptr, 0);
        @(negedge clk);
        reset = 1'b0;

        // First request: one-edge latency
        step(8'h01);
        check("tp1_grant", grant, 8'h01);
        check("tp1_id", grant_id, 0);
        step(8'h00);

        // Back-to-back handover and pointer wrap
        do_reset();
        step(8'h81);
        check("tp2_first", grant, 8'h01);
        step(8'h80);
        check("tp2_handover", grant, 8'h80);
        check("tp2_id7", grant_id, 7);
        step(8'h00);
        check("tp2_idle", grant, 8'h00);
        check("tp2_wrap", dbg.ptr, 0);

        // Full rotation with every requester active
        do_reset();
        step(8'hFF);
        for (int k = 0; k < 8; k++) begin
            step(8'hFF & ~(8'h01 << k));
            check("rot_next", grant, 8'h01 << ((k + 1) % 8));
            step(8'hFF);
        end
        step(8'h00);

        // Unrelated bits toggling do not disturb a held grant
        do_reset();
        step(8'h04);
        for (int k = 0; k < 6; k++) begin
            step(8'h04 | ((k % 2) ? 8'h08 : 8'h20) | ((k % 3 == 0) ? 8'h28 : 8'h00));
`ifndef MY_RR_ARB_TIMEOUT_EN
            check("hold2", grant, 8'h04);
`endif
        end

        // Asynchronous reset in the middle of a grant
        do_reset();
        step(8'h04);
        @(posedge clk);
        model_step(8'h04);
        #3;
        reset = 1'b1;
        #1;
        check("async_grant", grant, 8'h00);
        check("async_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

`ifdef MY_RR_ARB_TIMEOUT_EN
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            step(8'h03);
            check("tmo_rotate", grant, 8'h01 << (((n - 1) / HM) % 2));
        end
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(8'h01);
            check("tmo_alone", grant, 8'h01);
        end
`else
        do_reset();
        for (int n = 0; n < 100; n++) begin
            step(8'h03);
            check("no_tmo_hold", grant, 8'h01);
        end
`endif

        // Randomized traffic, biased towards the holder keeping its request
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            if (m_holder >= 0 && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
